// File: rtl/sdf_fft_ctrl.sv
// Sequencing controller for a radix-2 single-path delay-feedback FFT pipeline.
// Generates the common advance enable, per-stage butterfly selects and twiddle
// addresses, output framing, frame alignment errors and end-of-stream flushing.
module sdf_fft_ctrl #(
    parameter  int N     = 64,
    localparam int LOG2N = $clog2(N),
    localparam int TW_W  = LOG2N - 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic                    flush,
    output logic                    in_ready,
    output logic                    adv,
    output logic                    pad,
    output logic [LOG2N-1:0]        stage_sel,
    output logic [LOG2N*TW_W-1:0]   tw_addr,
    output logic                    out_valid,
    output logic                    out_sof,
    output logic                    frame_err,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } state_t;

    state_t             state, state_n;
    logic [LOG2N-1:0]   cnt, cnt_n;
    logic               flush_lat, flush_lat_n;
    logic               err_n;
    logic               adv_i, ready_i, pad_i, ov_i;
    logic [LOG2N-1:0]   k, m;

    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] CNT_FILL = LOG2N'(N - 2);

    // State, sample counter, sticky flush request and registered error pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            flush_lat <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            flush_lat <= flush_lat_n;
            frame_err <= err_n;
        end
    end

    // Next-state, counter and handshake/pipeline control decode
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        flush_lat_n = flush_lat;
        err_n       = 1'b0;
        ready_i     = 1'b1;
        adv_i       = 1'b0;
        pad_i       = 1'b0;
        ov_i        = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_sof) begin
                        adv_i   = 1'b1;
                        state_n = FILL;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            FILL: begin
                adv_i = in_valid;
                if (flush) begin
                    flush_lat_n = 1'b1;
                end
                if (adv_i && cnt == CNT_FILL) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                // A frame boundary with a pending flush is already the first
                // flush cycle, so the upstream sample is refused here.
                if (cnt == '0 && (flush_lat || flush)) begin
                    ready_i     = 1'b0;
                    adv_i       = 1'b1;
                    pad_i       = 1'b1;
                    ov_i        = 1'b1;
                    flush_lat_n = 1'b0;
                    state_n     = FLUSH;
                end else begin
                    adv_i = in_valid;
                    ov_i  = in_valid;
                    if (flush) begin
                        flush_lat_n = 1'b1;
                    end
                    if (in_valid && in_sof && cnt != '0) begin
                        err_n = 1'b1;
                    end
                end
            end
            FLUSH: begin
                ready_i = 1'b0;
                adv_i   = 1'b1;
                pad_i   = 1'b1;
                ov_i    = 1'b1;
                if (cnt == CNT_FILL) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (adv_i) begin
            cnt_n = cnt + 1'b1;
        end
        if (state == FLUSH && cnt == CNT_FILL) begin
            cnt_n = '0;
        end
    end

    // Output drive; reset forces idle values immediately even with live inputs
    always_comb begin
        in_ready  = ready_i;
        adv       = adv_i;
        pad       = pad_i;
        out_valid = ov_i;
        if (reset) begin
            in_ready  = 1'b1;
            adv       = 1'b0;
            pad       = 1'b0;
            out_valid = 1'b0;
        end
        out_sof = out_valid && (cnt == CNT_LAST);
        busy    = (state != IDLE);
    end

    // Per-stage butterfly select and twiddle address from the stage-local index
    always_comb begin
        stage_sel = '0;
        tw_addr   = '0;
        k         = '0;
        m         = '0;
        for (int unsigned s = 0; s < LOG2N; s++) begin
            k = cnt - LOG2N'(N - (N >> s));
            stage_sel[s] = k[LOG2N-1-s];
            m = k & LOG2N'((N >> (s + 1)) - 1);
            tw_addr[s*TW_W +: TW_W] = TW_W'(m << s);
        end
    end

endmodule

// File: tb/tb_sdf_fft_ctrl.sv
// Directed bench for sdf_fft_ctrl at N=8 with a scoreboard on output samples.
module tb_sdf_fft_ctrl;

    localparam int N     = 8;
    localparam int LOG2N = 3;
    localparam int TW_W  = 2;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_sof = 1'b0;
    logic                  flush = 1'b0;
    logic                  in_ready, adv, pad, out_valid, out_sof, frame_err, busy;
    logic [LOG2N-1:0]      stage_sel;
    logic [LOG2N*TW_W-1:0] tw_addr;

    int total = 0;
    int bad   = 0;

    // expected {out_sof, pad} for each output sample, in order
    logic [1:0] sb[$];

    // hand-derived selects / twiddle words indexed by cnt
    // sel: s0 = cnt>=4, s1 = bit1 of (cnt-4), s2 = cnt odd
    // tw : stage0 = cnt%4, stage1 = 2*((cnt-4)%2), stage2 = 0
    logic [2:0] sel_tab [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    logic [5:0] tw_tab  [8] = '{6'd0, 6'd9, 6'd2, 6'd11, 6'd0, 6'd9, 6'd2, 6'd11};

    sdf_fft_ctrl #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .flush     (flush),
        .in_ready  (in_ready),
        .adv       (adv),
        .pad       (pad),
        .stage_sel (stage_sel),
        .tw_addr   (tw_addr),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // in = {valid, sof, flush}; ex = {adv, ready, out_valid, out_sof, pad, frame_err}
    task automatic cyc(input logic [2:0] in, input logic [5:0] ex, input int c);
        @(negedge clk);
        in_valid = in[2];
        in_sof   = in[1];
        flush    = in[0];
        if (ex[3]) sb.push_back({ex[2], ex[1]});
        #2;
        chk("adv", adv, ex[5]);
        chk("in_ready", in_ready, ex[4]);
        chk("out_valid", out_valid, ex[3]);
        chk("pad", pad, ex[1]);
        chk("frame_err", frame_err, ex[0]);
        chk("stage_sel", stage_sel, sel_tab[c]);
        chk("tw_addr", tw_addr, tw_tab[c]);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_adv"}, adv, 0);
        chk({tag, "_pad"}, pad, 0);
        chk({tag, "_ov"}, out_valid, 0);
        chk({tag, "_osof"}, out_sof, 0);
        chk({tag, "_err"}, frame_err, 0);
        chk({tag, "_sel"}, stage_sel, 0);
        chk({tag, "_tw"}, tw_addr, 0);
    endtask

    // Scoreboard monitor: every presented output sample is matched in order
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: out_valid=1 with no expected sample at %0t", $time);
                end else begin
                    logic [1:0] e;
                    e = sb.pop_front();
                    chk("sb_out_sof", out_sof, e[1]);
                    chk("sb_pad", pad, e[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        @(negedge clk);
        @(negedge clk);
        #2;
        chk_reset_vals("rst");
        reset = 1'b0;

        // one full frame, flush requested on the last sample
        cyc(3'b110, 6'b110000, 0);
        for (int i = 1; i <= 6; i++) cyc(3'b100, 6'b110000, i);
        cyc(3'b101, 6'b111100, 7);
        chk("busy_run", busy, 1);
        cyc(3'b000, 6'b101010, 0);
        for (int i = 1; i <= 6; i++) cyc(3'b000, 6'b101010, i);
        cyc(3'b000, 6'b010000, 0);
        chk("busy_after_flush", busy, 0);

        // gaps, back-to-back frame, misaligned sof, flush racing a sof
        cyc(3'b110, 6'b110000, 0);
        cyc(3'b000, 6'b010000, 1);
        cyc(3'b000, 6'b010000, 1);
        cyc(3'b100, 6'b110000, 1);
        cyc(3'b000, 6'b010000, 2);
        for (int i = 2; i <= 6; i++) cyc(3'b100, 6'b110000, i);
        cyc(3'b100, 6'b111100, 7);
        cyc(3'b110, 6'b111000, 0);
        cyc(3'b100, 6'b111000, 1);
        cyc(3'b100, 6'b111000, 2);
        cyc(3'b000, 6'b010000, 3);
        cyc(3'b110, 6'b111000, 3);
        cyc(3'b100, 6'b111001, 4);
        cyc(3'b100, 6'b111000, 5);
        cyc(3'b100, 6'b111000, 6);
        cyc(3'b100, 6'b111100, 7);
        cyc(3'b111, 6'b101010, 0);
        for (int i = 1; i <= 6; i++) cyc(3'b000, 6'b101010, i);
        cyc(3'b000, 6'b010000, 0);
        chk("busy_idle2", busy, 0);

        // IDLE: orphan sample is dropped and flagged, flush ignored
        cyc(3'b100, 6'b010000, 0);
        cyc(3'b001, 6'b010001, 0);
        cyc(3'b000, 6'b010000, 0);
        chk("busy_idle3", busy, 0);

        // asynchronous reset in RUN at cnt==5
        cyc(3'b110, 6'b110000, 0);
        for (int i = 1; i <= 6; i++) cyc(3'b100, 6'b110000, i);
        cyc(3'b100, 6'b111100, 7);
        for (int i = 0; i <= 4; i++) cyc(3'b100, 6'b111000, i);
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = 1'b1;
        flush    = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        cyc(3'b110, 6'b110000, 0);
        cyc(3'b100, 6'b110000, 1);
        chk("busy_refill", busy, 1);

        @(negedge clk);
        in_valid = 1'b0;
        #4;
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
